// File: rtl/spi_seq_pkg.sv
// Shared types and defaults for the SPI byte sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int SPI_BYTE_W         = 8;
  localparam int DEF_FIFO_DEPTH     = 16;
  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/spi_master_seq_if.sv
// Host streams, master-side handshake and status of the SPI byte sequencer.
// Latency: n/a (wiring only).
// Backpressure: tx_valid/tx_ready and rx_valid/rx_ready are plain valid/ready.
// Modports: slave = the sequencer itself, master = the environment that
// drives host bytes and models spi_module_master.
interface spi_master_seq_if import spi_seq_pkg::*; #(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [SPI_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  m_spi_en;
  logic [SPI_BYTE_W-1:0] m_mosi_data;
  logic [SPI_BYTE_W-1:0] m_miso_data;
  logic                  m_payload_done;
  logic                  busy;
  logic                  timeout_err;
  logic                  err_clr;
  logic [LVL_W-1:0]      tx_level;
  logic [LVL_W-1:0]      rx_level;

  modport slave (
    input  tx_data, tx_valid, rx_ready, m_miso_data, m_payload_done, err_clr,
    output tx_ready, rx_data, rx_valid, m_spi_en, m_mosi_data, busy,
           timeout_err, tx_level, rx_level
  );

  modport master (
    output tx_data, tx_valid, rx_ready, m_miso_data, m_payload_done, err_clr,
    input  tx_ready, rx_data, rx_valid, m_spi_en, m_mosi_data, busy,
           timeout_err, tx_level, rx_level
  );
endinterface

// File: rtl/spi_byte_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Latency: a word pushed on edge N is visible at out_dat after edge N.
// Backpressure: in_rdy drops when full unless a pop happens in the same cycle.
// Ports: clk/rst_n, in_dat/in_vld/in_rdy push side, out_dat/out_vld/out_rdy
// pop side, level = current occupancy (0..DEPTH).
module spi_byte_fifo import spi_seq_pkg::*; #(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int W     = SPI_BYTE_W,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_dat,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [W-1:0]     out_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [LVL_W-1:0] level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign out_vld = (level != '0);
  assign pop     = out_vld && out_rdy;
  // A pop frees the slot on the same edge, so a full FIFO still takes a push.
  assign in_rdy  = !full || pop;
  assign push    = in_vld && in_rdy;
  // Storage is not reset; mask the head so an empty FIFO reads as zero.
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end
endmodule

// File: rtl/spi_master_seq.sv
// Byte sequencer feeding spi_module_master from a TX FIFO and collecting replies in an RX FIFO.
// Latency: byte accepted on edge N into an idle, empty block raises m_spi_en after edge N+1.
// Backpressure: tx_ready = TX FIFO room; a full RX FIFO stalls new bytes in IDLE, nothing is dropped.
// Ports: clk, rst_n (async, active-low), bus (slave modport): host TX/RX
// streams, master handshake (m_spi_en, m_mosi_data, m_miso_data,
// m_payload_done), status (busy, timeout_err/err_clr, tx_level, rx_level).
module spi_master_seq import spi_seq_pkg::*; #(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int LVL_W         = $clog2(FIFO_DEPTH + 1)
) (
  input logic             clk,
  input logic             rst_n,
  spi_master_seq_if.slave bus
);
  localparam int GW   = $clog2(GAP_CYCLES + 1);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                state, state_nxt;
  logic                  en_q, en_nxt;
  logic [SPI_BYTE_W-1:0] mosi_q, mosi_nxt;
  logic [WD_W-1:0]       wd_cnt, wd_nxt;
  logic [GW-1:0]         gap_cnt, gap_nxt;
  logic                  err_q, err_nxt;
  logic                  start;
  logic                  can_start;
  logic                  to_evt;
  logic                  tx_pop;
  logic                  rx_push;
  logic                  tx_head_vld;
  logic [SPI_BYTE_W-1:0] tx_head;
  logic                  rx_in_rdy;

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(SPI_BYTE_W)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_dat  (bus.tx_data),
    .in_vld  (bus.tx_valid),
    .in_rdy  (bus.tx_ready),
    .out_dat (tx_head),
    .out_vld (tx_head_vld),
    .out_rdy (tx_pop),
    .level   (bus.tx_level)
  );

  // RX room is reserved before a byte starts, so rx_in_rdy is always 1 on a push.
  spi_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(SPI_BYTE_W)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_dat  (bus.m_miso_data),
    .in_vld  (rx_push),
    .in_rdy  (rx_in_rdy),
    .out_dat (bus.rx_data),
    .out_vld (bus.rx_valid),
    .out_rdy (bus.rx_ready),
    .level   (bus.rx_level)
  );

  assign can_start = tx_head_vld && (bus.rx_level != LVL_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      en_q    <= 1'b0;
      mosi_q  <= '0;
      wd_cnt  <= '0;
      gap_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      en_q    <= en_nxt;
      mosi_q  <= mosi_nxt;
      wd_cnt  <= wd_nxt;
      gap_cnt <= gap_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    en_nxt    = en_q;
    mosi_nxt  = mosi_q;
    wd_nxt    = wd_cnt;
    gap_nxt   = gap_cnt;
    start     = 1'b0;
    to_evt    = 1'b0;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;

    case (state)
      IDLE: start = can_start;
      XFER: begin
        if (bus.m_payload_done) begin
          rx_push   = 1'b1;
          en_nxt    = 1'b0;
          gap_nxt   = GW'(GAP_CYCLES);
          state_nxt = GAP;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1))) begin
          // This edge completes the last allowed XFER cycle: abort, drop the byte.
          to_evt    = 1'b1;
          en_nxt    = 1'b0;
          gap_nxt   = GW'(GAP_CYCLES);
          state_nxt = GAP;
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
        end
      end
      GAP: begin
        // The counter's final step doubles as the IDLE start check, so the
        // next byte can go out without an extra idle cycle and m_spi_en is
        // low for exactly GAP_CYCLES cycles.
        if (gap_cnt == GW'(1)) begin
          gap_nxt   = '0;
          state_nxt = IDLE;
          start     = can_start;
        end else begin
          gap_nxt = gap_cnt - GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start) begin
      tx_pop    = 1'b1;
      mosi_nxt  = tx_head;
      en_nxt    = 1'b1;
      wd_nxt    = '0;
      state_nxt = XFER;
    end
  end

  // A timeout on the same edge as err_clr leaves the flag set.
  assign err_nxt = to_evt ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);

  assign bus.m_spi_en    = en_q;
  assign bus.m_mosi_data = mosi_q;
  assign bus.timeout_err = err_q;
  assign bus.busy        = (state != IDLE) || (bus.tx_level != '0);
endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
Byte-stream sequencer that sits directly upstream of spi_module_master. It buffers host TX bytes in a FIFO and hands them to the master one byte at a time over the spi_en / spi_mosi_data / payload_done handshake. It captures each returned spi_miso_data byte into an RX FIFO. It enforces a minimum inter-byte gap and a per-byte watchdog, so the host sees a plain valid/ready stream in each direction.

Parameters:
FIFO_DEPTH, 16, entries per FIFO; power of 2, >= 2
GAP_CYCLES, 2, clk cycles m_spi_en is held low between bytes; >= 1
TIMEOUT_CYCLES, 4096, max clk cycles in XFER before abort; 0 disables the watchdog
LVL_W, $clog2(FIFO_DEPTH+1), derived width of the level outputs

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
tx_data  in  8  host byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX FIFO not full
rx_data  out  8  received byte, head of RX FIFO
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  host pops RX head
m_spi_en  out  1  to master spi_en
m_mosi_data  out  8  to master spi_mosi_data
m_miso_data  in  8  from master spi_miso_data
m_payload_done  in  1  from master payload_done, 1-cycle pulse
busy  out  1  state != IDLE or tx_level != 0
timeout_err  out  1  sticky watchdog flag
err_clr  in  1  clears timeout_err
tx_level  out  LVL_W  TX FIFO occupancy
rx_level  out  LVL_W  RX FIFO occupancy

Behaviour:
- Reset is asynchronous and immediate. Outputs take these values: m_spi_en=0, m_mosi_data=0, tx_ready=1, rx_valid=0, rx_data=0, levels=0, timeout_err=0, busy=0, state=IDLE.
- FIFOs:
  - Synchronous and first-word-fall-through.
  - Push when valid&&ready; pop when valid&&ready.
  - Simultaneous push+pop when full: both occur and the level is unchanged.
  - Simultaneous push+pop when empty: the pushed word is valid next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, XFER, GAP.
- IDLE:
  - Start condition: TX non-empty and rx_level < FIFO_DEPTH, which reserves the RX slot.
  - On start: pop the TX head into m_mosi_data, set m_spi_en=1 from the next cycle, clear the watchdog count, go to XFER.
  - Latency: a byte accepted on edge N into an empty, idle block gives m_spi_en=1 after edge N+1.
- XFER:
  - m_spi_en=1 and m_mosi_data stay stable.
  - On m_payload_done: write m_miso_data into the RX FIFO on that edge, set m_spi_en=0 next cycle, load the gap counter with GAP_CYCLES, go to GAP.
  - Watchdog (TIMEOUT_CYCLES != 0): when the count reaches TIMEOUT_CYCLES without m_payload_done, set m_spi_en=0 and timeout_err=1. The byte is dropped and nothing is pushed to RX. Go to GAP.
- GAP: m_spi_en=0; decrement the counter and go to IDLE at 0. m_spi_en is low for exactly GAP_CYCLES cycles between bytes.
- m_payload_done outside XFER is ignored.
- timeout_err: err_clr clears it. A timeout event in the same cycle as err_clr wins.
- Bytes are sent in push order; each RX entry corresponds 1:1 to a completed TX byte.
- rx_level never exceeds FIFO_DEPTH. An RX-full condition stalls in IDLE and never drops data.
- rst_n low mid-XFER: m_spi_en drops asynchronously. In-flight and queued data are discarded.

Decomposition:
- Package spi_seq_pkg holds:
  - state_t enum (IDLE, XFER, GAP);
  - SPI_BYTE_W=8;
  - shared default constants for GAP_CYCLES and TIMEOUT_CYCLES.
- Sub-module spi_byte_fifo: parameterised sync FWFT FIFO with level output, instantiated twice (TX and RX).

Test Plan:
- Push 0xA5; stub master pulses payload_done 20 cycles after m_spi_en rises, with miso=0x3C -> m_spi_en high 2 cycles after tx accept, for 20 cycles, m_mosi_data=0xA5 throughout; rx_data=0x3C, rx_level=1, busy=0 after GAP.
- Push 0x00..0x0F back-to-back with rx_ready=0 and stub done after 10 cycles -> bytes sent in order, m_spi_en low exactly 2 cycles between bytes, rx_level=16. A 17th push is not started until one rx pop, then starts 1 cycle later.
- Stub never pulses done, push 18 bytes -> 17 accepted (1 in XFER + 16 queued), tx_ready=0 on the 18th, tx_level=16.
- TIMEOUT_CYCLES=64, no done -> m_spi_en falls after 64 XFER cycles, timeout_err=1, rx_level=0. Next byte proceeds normally. err_clr pulse -> timeout_err=0.
- rst_n low mid-XFER, 5 bytes queued -> m_spi_en=0 immediately, tx_level=rx_level=0. After release: tx_ready=1, no spurious m_spi_en.
- Integrate with real spi_module_master and spi_module_slave (CPOL=0, CPHA=0, 10 MHz SPI): 100 random bytes -> every host rx byte equals the slave's spi_miso_data for that byte, and the slave's received byte equals the pushed byte; zero mismatches.
